mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_WIDTH  first source word address.
REQ-007 dst_addr  input  ADDR_WIDTH  first destination word address.
REQ-008 length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
REQ-009 addr_a  output  ADDR_WIDTH  read address to memory port A.
REQ-010 we_a  output  1  port A write enable; tied 0.
REQ-011 out_a  input  DATA_WIDTH  port A read data, valid one cycle after addr_a.
REQ-012 addr_b  output  ADDR_WIDTH  write address to memory port B.
REQ-013 data_b  output  DATA_WIDTH  write data to port B.
REQ-014 we_b  output  1  port B write enable.
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle pulse on completion.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with length>0, IDLE->DONE on start with length=0, RUN->DRAIN after last read issued, DRAIN->DONE after last write, DONE->IDLE unconditionally.
REQ-018 On start acceptance the block latches src_addr, dst_addr, length; later input changes have no effect.
REQ-019 Direction: descending when dst>src and dst<src+length (unwrapped compare), otherwise ascending; descending starts at src+length-1 / dst+length-1.
REQ-020 RUN issues one read per cycle on addr_a; each word is written on port B (we_b=1, data_b=out_a, addr_b=matching dst) exactly one cycle after its read.
REQ-021 Throughput one word/cycle; length L yields exactly L we_b cycles, first write 2 cycles after the start-sampling edge, done pulse in the cycle after the last write.
REQ-022 Addresses wrap modulo 2^ADDR_WIDTH (0x3FF+1 -> 0x000, 0x000-1 -> 0x3FF).
REQ-023 length=0: no we_b, done pulses 1 cycle after start sampled.
REQ-024 start while busy is ignored.
REQ-025 we_b low, addr_b/data_b hold previous values whenever no write occurs.
REQ-026 busy high in RUN, DRAIN, DONE; done high only in DONE.

Reset
REQ-027 reset_n low forces IDLE and busy=0, done=0, we_b=0, addr_a=0, addr_b=0, data_b=0 immediately, independent of clk.
REQ-028 Reset mid-copy aborts without further writes; no done pulse for the aborted copy.

Structure
REQ-029 State encoding and DATA_WIDTH/ADDR_WIDTH defaults reside in a shared package mem_pkg.
REQ-030 No sub-module; a single FSM plus address/count registers.

Verification
REQ-031 Preload 0x000=0xFEFE, 0x001=0xEFEF; copy src=0x000 dst=0x100 len=2 -> 0x100=0xFEFE, 0x101=0xEFEF, exactly 2 we_b cycles, done 1 cycle after last write.
REQ-032 Overlap: 0x010..0x013 = 1,2,3,4; copy src=0x010 dst=0x011 len=4 -> descending order, 0x011..0x014 = 1,2,3,4.
REQ-033 Wrap: src=0x3FE dst=0x200 len=4 -> reads 0x3FE,0x3FF,0x000,0x001; writes 0x200..0x203.
REQ-034 len=0 -> no we_b, done pulse 1 cycle after start, busy high for exactly that 1 cycle.
REQ-035 Assert reset_n low mid-copy of len=8 after 3 writes -> we_b=0 immediately, busy=0, no done, 0x103..0x107 unchanged.
REQ-036 Pulse start during busy with different addresses -> ignored, original copy completes unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine: default widths and FSM state encoding.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies a block of words from memory port A to port B, one word per cycle, overlap-safe.
// First write 2 cycles after start is accepted, done 1 cycle after the last write; no backpressure.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic                  we_a,
    input  logic [DATA_WIDTH-1:0] out_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  we_b,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    copy_state_t           state;
    copy_state_t           state_nxt;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  desc;
    logic                  rd_pend;
    logic                  accept;
    logic                  overlap;
    logic                  last_rd;
    logic [ADDR_WIDTH:0]   src_end;
    logic [ADDR_WIDTH-1:0] len_low;
    logic [ADDR_WIDTH-1:0] src_top;
    logic [ADDR_WIDTH-1:0] dst_top;

    assign we_a    = 1'b0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign accept  = (state == IDLE) && start;
    assign last_rd = (cnt == CNT_ONE);

    // Overlap test is done without wrap so a destination just past the source end stays ascending.
    assign src_end = {1'b0, src_addr} + length;
    assign overlap = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
    assign len_low = length[ADDR_WIDTH-1:0];
    assign src_top = src_addr + len_low - ADDR_ONE;
    assign dst_top = dst_addr + len_low - ADDR_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_rd) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final word is on port B and nothing is still in flight.
                if (we_b && !rd_pend) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_a  <= '0;
            addr_b  <= '0;
            data_b  <= '0;
            we_b    <= 1'b0;
            wr_ptr  <= '0;
            cnt     <= '0;
            desc    <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            // Every RUN cycle issues a read; its data returns next cycle and is registered onto port B.
            rd_pend <= (state == RUN);
            we_b    <= rd_pend;
            if (rd_pend) begin
                addr_b <= wr_ptr;
                data_b <= out_a;
                wr_ptr <= desc ? (wr_ptr - ADDR_ONE) : (wr_ptr + ADDR_ONE);
            end
            if (accept) begin
                desc   <= overlap;
                cnt    <= length;
                addr_a <= overlap ? src_top : src_addr;
                wr_ptr <= overlap ? dst_top : dst_addr;
            end else if (state == RUN) begin
                cnt    <= cnt - CNT_ONE;
                addr_a <= desc ? (addr_a - ADDR_ONE) : (addr_a + ADDR_ONE);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a dual-port synchronous-read memory model.
module tb_mem_copy_engine;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length   = '0;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          we_a;
    logic          we_b;
    logic          busy;
    logic          done;
    logic [DW-1:0] out_a;
    logic [DW-1:0] data_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_we   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat  = '0;

    int total = 0;
    int bad   = 0;

    int            wr_k [$];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [AW-1:0] rd_a [$];
    logic [DW-1:0] exp_d [$];
    int            done_k;
    int            done_n;
    int            busy_n;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .addr_a   (addr_a),
        .we_a     (we_a),
        .out_a    (out_a),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .we_b     (we_b),
        .busy     (busy),
        .done     (done)
    );

    always @(posedge clk) begin
        out_a <= mem[addr_a];
        if (we_b) mem[addr_b] <= data_b;
        else if (pl_we) mem[pl_addr] <= pl_dat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Called at a negedge; cycle k=1 is the cycle right after the start-sampling edge.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] n, input bit poke);
        int end_k;
        wr_k.delete(); wr_a.delete(); wr_d.delete(); rd_a.delete();
        done_k = -1; done_n = 0; busy_n = 0;
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        end_k = 60;
        for (int k = 1; k <= end_k; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= int'(n)) rd_a.push_back(addr_a);
            if (we_b) begin
                wr_k.push_back(k);
                wr_a.push_back(addr_b);
                wr_d.push_back(data_b);
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    end_k  = k + 2;
                end
            end
            if (poke && k == 2) begin
                start = 1'b1; src_addr = 10'h300; dst_addr = 10'h180; length = 11'd2;
            end else if (poke) begin
                start = 1'b0; src_addr = AW'(k); dst_addr = AW'(k + 7); length = 11'd9;
            end
        end
        start = 1'b0;
        if (done_k < 0) chk("timeout_no_done", 0, 1);
    endtask

    task automatic check_copy(input string tag, input int n, input logic [AW-1:0] rs,
                              input logic [AW-1:0] ws, input bit dsc);
        logic [AW-1:0] ea;
        chk({tag, " nwr"}, wr_k.size(), n);
        chk({tag, " done_k"}, done_k, (n == 0) ? 1 : n + 3);
        chk({tag, " done_n"}, done_n, 1);
        chk({tag, " busy_n"}, busy_n, (n == 0) ? 1 : n + 3);
        for (int i = 0; i < n && i < wr_k.size(); i++) begin
            ea = dsc ? rs - AW'(i) : rs + AW'(i);
            chk({tag, " rd_addr"}, rd_a[i], ea);
            ea = dsc ? ws - AW'(i) : ws + AW'(i);
            chk({tag, " wr_addr"}, wr_a[i], ea);
            chk({tag, " wr_k"}, wr_k[i], i + 3);
            chk({tag, " wr_dat"}, wr_d[i], exp_d[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        int nw;
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst we_b", we_b, 0);
        chk("rst we_a", we_a, 0);
        chk("rst addr_a", addr_a, 0);
        chk("rst addr_b", addr_b, 0);
        chk("rst data_b", data_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic two-word copy
        wr_mem(10'h000, 16'hFEFE); wr_mem(10'h001, 16'hEFEF);
        wr_mem(10'h100, 16'h0000); wr_mem(10'h101, 16'h0000); wr_mem(10'h102, 16'h1234);
        exp_d = '{16'hFEFE, 16'hEFEF};
        run_copy(10'h000, 10'h100, 11'd2, 1'b0);
        check_copy("basic", 2, 10'h000, 10'h100, 1'b0);
        chk("basic mem100", mem[10'h100], 16'hFEFE);
        chk("basic mem101", mem[10'h101], 16'hEFEF);
        chk("basic mem102", mem[10'h102], 16'h1234);

        // Overlapping forward move must copy top-down
        for (int i = 0; i < 4; i++) wr_mem(AW'(10'h010 + i), DW'(i + 1));
        wr_mem(10'h014, 16'h0000);
        exp_d = '{16'd4, 16'd3, 16'd2, 16'd1};
        run_copy(10'h010, 10'h011, 11'd4, 1'b0);
        check_copy("ovl", 4, 10'h013, 10'h014, 1'b1);
        for (int i = 0; i < 4; i++) chk("ovl mem", mem[AW'(10'h011 + i)], DW'(i + 1));

        // Source wraps past the top of memory
        wr_mem(10'h3FE, 16'h00A1); wr_mem(10'h3FF, 16'h00A2);
        wr_mem(10'h000, 16'h00A3); wr_mem(10'h001, 16'h00A4);
        exp_d = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        run_copy(10'h3FE, 10'h200, 11'd4, 1'b0);
        check_copy("wrap", 4, 10'h3FE, 10'h200, 1'b0);
        for (int i = 0; i < 4; i++) chk("wrap mem", mem[AW'(10'h200 + i)], DW'(16'h00A1 + i));

        // Descending copy whose destination wraps to address 0
        exp_d = '{16'h00A2, 16'h00A1};
        run_copy(10'h3FE, 10'h3FF, 11'd2, 1'b0);
        check_copy("dwrap", 2, 10'h3FF, 10'h000, 1'b1);
        chk("dwrap mem3ff", mem[10'h3FF], 16'h00A1);
        chk("dwrap mem000", mem[10'h000], 16'h00A2);

        // Zero length
        run_copy(10'h005, 10'h006, 11'd0, 1'b0);
        check_copy("len0", 0, 10'h000, 10'h000, 1'b0);

        // Start pulse while busy must be ignored
        for (int i = 0; i < 4; i++) wr_mem(AW'(10'h020 + i), DW'(16'h00B0 + i));
        wr_mem(10'h180, 16'h7777);
        exp_d = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
        run_copy(10'h020, 10'h140, 11'd4, 1'b1);
        check_copy("busy_start", 4, 10'h020, 10'h140, 1'b0);
        chk("busy_start mem180", mem[10'h180], 16'h7777);

        // Reset in the middle of an 8-word copy, after three writes
        for (int i = 0; i < 8; i++) begin
            wr_mem(AW'(i), DW'(16'h00C0 + i));
            wr_mem(AW'(10'h100 + i), 16'h5555);
        end
        src_addr = 10'h000; dst_addr = 10'h100; length = 11'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort pre we_b", we_b, 1);
        reset_n = 1'b0;
        #1;
        chk("abort we_b", we_b, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort addr_b", addr_b, 0);
        chk("abort data_b", data_b, 0);
        nd = 0; nw = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
            if (we_b) nw++;
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
            if (we_b) nw++;
        end
        chk("abort no done", nd, 0);
        chk("abort no writes", nw, 0);
        for (int i = 0; i < 3; i++) chk("abort copied", mem[AW'(10'h100 + i)], DW'(16'h00C0 + i));
        for (int i = 3; i < 8; i++) chk("abort untouched", mem[AW'(10'h100 + i)], 16'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
